apu_decimation_filter: RTL and testbench

//  Polyphase 64-tap FIR lowpass filter with 16:1 decimation. It takes signed
//  16-bit samples at the oversampled rate (16 * 48 kHz = 768 kHz) and emits one

---
 rtl/apu_decimation_filter.sv | 114 +++++++++++
 tb/tb_apu_decimation_filter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/apu_decimation_filter.sv
// Polyphase 64-tap FIR lowpass with 16:1 decimation for the APU capture path.
// Four rotating accumulators each build one overlapping output frame, so no delay line is kept.
module apu_decimation_filter #(
   parameter int W_SAMPLE = 16,
   parameter int W_COEFF  = 9,
   parameter int DECIM    = 16,
   parameter int NACC     = 4,
   parameter int SHIFT    = 12,
   // 22 kHz windowed-sinc table, symmetric, so its listing order is irrelevant
   parameter logic [DECIM*NACC*W_COEFF-1:0] COEFF = {
      9'h000, 9'h1FF, 9'h1FE, 9'h1FD, 9'h1FC, 9'h1FB, 9'h1FA, 9'h1F9,
      9'h1F8, 9'h1F8, 9'h1F8, 9'h1F9, 9'h1FB, 9'h1FE, 9'd2,   9'd8,
      9'd16,  9'd26,  9'd38,  9'd52,  9'd67,  9'd84,  9'd102, 9'd120,
      9'd139, 9'd157, 9'd175, 9'd191, 9'd205, 9'd217, 9'd226, 9'd232,
      9'd232, 9'd226, 9'd217, 9'd205, 9'd191, 9'd175, 9'd157, 9'd139,
      9'd120, 9'd102, 9'd84,  9'd67,  9'd52,  9'd38,  9'd26,  9'd16,
      9'd8,   9'd2,   9'h1FE, 9'h1FB, 9'h1F9, 9'h1F8, 9'h1F8, 9'h1F8,
      9'h1F9, 9'h1FA, 9'h1FB, 9'h1FC, 9'h1FD, 9'h1FE, 9'h1FF, 9'h000
   }
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clr,
   input  logic                       en,
   input  logic signed [W_SAMPLE-1:0] d,
   output logic signed [W_SAMPLE-1:0] q,
   output logic                       q_valid
);

   localparam int TAPS  = DECIM * NACC;
   localparam int W_ACC = W_SAMPLE + W_COEFF + $clog2(TAPS);
   localparam int W_PH  = $clog2(DECIM);
   localparam int W_PTR = $clog2(NACC);

   localparam logic signed [W_ACC-1:0] Q_MAX = W_ACC'(2**(W_SAMPLE-1) - 1);
   localparam logic signed [W_ACC-1:0] Q_MIN = ~Q_MAX;

   logic        [W_PH-1:0]     phase;
   logic        [W_PTR-1:0]    ptr;      // physical slot holding the newest frame
   logic        [W_PTR-1:0]    warm;
   logic signed [W_ACC-1:0]    acc     [NACC];
   logic signed [W_ACC-1:0]    acc_nxt [NACC];
   logic signed [W_ACC-1:0]    prod    [NACC];
   logic signed [W_COEFF-1:0]  coef    [NACC];
   logic        [W_PTR-1:0]    age;
   logic        [W_PTR-1:0]    oldest;
   logic signed [W_ACC-1:0]    final_sum;
   logic signed [W_ACC-1:0]    shifted;
   logic signed [W_SAMPLE-1:0] q_sat;
   logic                       frame_end;

   assign frame_end = en && (phase == W_PH'(DECIM - 1));
   assign oldest    = W_PTR'(ptr + 1'b1);

   // NOTE: every variable gets a default before any branch so no latch is inferred.
   always_comb begin
      age = '0;
      for (int a = 0; a < NACC; a++) begin
         coef[a] = $signed(COEFF[(a*DECIM + DECIM - 1 - int'(phase))*W_COEFF +: W_COEFF]);
         prod[a] = W_ACC'(d) * W_ACC'(coef[a]);
      end
      for (int s = 0; s < NACC; s++) begin
         age = W_PTR'(ptr - W_PTR'(s));
         if (frame_end && (age == W_PTR'(NACC - 1)))
            acc_nxt[s] = '0;
         else
            acc_nxt[s] = acc[s] + prod[age];
      end
      // The completed frame includes this strobe's product even though its slot is cleared
      final_sum = acc[oldest] + prod[NACC-1];
      shifted   = final_sum >>> SHIFT;
      if (shifted > Q_MAX)
         q_sat = W_SAMPLE'(Q_MAX);
      else if (shifted < Q_MIN)
         q_sat = W_SAMPLE'(Q_MIN);
      else
         q_sat = W_SAMPLE'(shifted);
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase   <= '0;
         ptr     <= '0;
         warm    <= W_PTR'(NACC - 1);
         q       <= '0;
         q_valid <= 1'b0;
         // NOTE: the accumulator array is reset explicitly; stale sums would leak into later frames.
         for (int s = 0; s < NACC; s++) acc[s] <= '0;
      end else begin
         q_valid <= 1'b0;
         if (clr) begin
            phase <= '0;
            ptr   <= '0;
            warm  <= W_PTR'(NACC - 1);
            for (int s = 0; s < NACC; s++) acc[s] <= '0;
         end else if (en) begin
            phase <= phase + 1'b1;
            for (int s = 0; s < NACC; s++) acc[s] <= acc_nxt[s];
            if (frame_end) begin
               ptr     <= oldest;
               q_valid <= 1'b1;
               if (warm != '0) begin
                  q    <= '0;
                  warm <= warm - 1'b1;
               end else begin
                  q <= q_sat;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_apu_decimation_filter.sv
// Scoreboard bench for apu_decimation_filter: three instances (default, all-1 and all-255
// coefficients); stimulus pushes hand-computed outputs, a monitor pops them on q_valid.
module tb_apu_decimation_filter;

   typedef struct {
      int val;
      int gap;   // expected clk count since previous q_valid, 0 = unchecked
   } exp_t;

   logic               clk;
   logic               rst_n;
   logic               clr     [3];
   logic               en      [3];
   logic signed [15:0] d       [3];
   logic signed [15:0] q       [3];
   logic               q_valid [3];

   exp_t exp_q [3][$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;
   int   last_cyc [3];

   apu_decimation_filter u_def (
      .clk(clk), .rst_n(rst_n), .clr(clr[0]), .en(en[0]), .d(d[0]), .q(q[0]), .q_valid(q_valid[0])
   );
   apu_decimation_filter #(.COEFF({64{9'd1}})) u_one (
      .clk(clk), .rst_n(rst_n), .clr(clr[1]), .en(en[1]), .d(d[1]), .q(q[1]), .q_valid(q_valid[1])
   );
   apu_decimation_filter #(.COEFF({64{9'd255}})) u_max (
      .clk(clk), .rst_n(rst_n), .clr(clr[2]), .en(en[2]), .d(d[2]), .q(q[2]), .q_valid(q_valid[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Monitor: every q_valid must have a pending expectation
   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 3; i++) begin
            if (q_valid[i]) begin
               check($sformatf("valid_expected_dut%0d", i), int'(exp_q[i].size() != 0), 1);
               if (exp_q[i].size() != 0) begin
                  mon_e = exp_q[i].pop_front();
                  check($sformatf("q_dut%0d", i), int'(q[i]), mon_e.val);
                  if (mon_e.gap != 0)
                     check($sformatf("gap_dut%0d", i), cyc - last_cyc[i], mon_e.gap);
               end
               last_cyc[i] = cyc;
            end
         end
      end
   end

   task automatic strobe(input int i, input int v);
      d[i]  = 16'(v);
      en[i] = 1'b1;
      @(posedge clk); #1;
      en[i] = 1'b0;
   endtask

   task automatic idle();
      @(posedge clk); #1;
   endtask

   task automatic run(input int i, input int v, input int n);
      for (int k = 0; k < n; k++) strobe(i, v);
   endtask

   // One 16-strobe frame; sample `pos` carries `pv`, the rest carry `v`
   task automatic frame(input int i, input int v, input int pos, input int pv,
                        input int spacing, input int expq, input int gap);
      exp_t e;
      for (int k = 0; k < 16; k++) begin
         if (k == 15) begin
            e.val = expq;
            e.gap = gap;
            exp_q[i].push_back(e);
         end
         strobe(i, (k == pos) ? pv : v);
         for (int s = 1; s < spacing; s++) idle();
      end
   endtask

   task automatic do_clr(input int i, input bit with_en, input int v);
      clr[i] = 1'b1;
      en[i]  = with_en;
      d[i]   = 16'(v);
      @(posedge clk); #1;
      clr[i] = 1'b0;
      en[i]  = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 64 && (exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0; t++)
         @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++)
         check($sformatf("drain_dut%0d", i), exp_q[i].size(), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int units1 [7];
      int exp1   [7];
      units1 = '{1, 2, 3, 4, -8, 0, 5};
      exp1   = '{0, 0, 0, 10, 1, -1, 1};

      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         clr[i] = 1'b0; en[i] = 1'b0; d[i] = '0; last_cyc[i] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("reset_q_dut%0d", i), int'(q[i]), 0);
         check($sformatf("reset_valid_dut%0d", i), int'(q_valid[i]), 0);
      end
      rst_n = 1'b1;
      idle();

      // Zero input: an output every 16 strobes, always 0
      for (int f = 0; f < 16; f++) frame(0, 0, -1, 0, 1, 0, (f == 0) ? 0 : 16);
      drain();

      // Impulses on default table: +4096 at phase 15 then -4096 at phase 0
      frame(0, 0, 15, 4096, 1, 8, 0);
      frame(0, 0, -1, 0, 1, 232, 16);
      frame(0, 0, -1, 0, 1, 16, 16);
      frame(0, 0, -1, 0, 1, 0, 16);
      frame(0, 0, 0, -4096, 1, 0, 16);
      frame(0, 0, -1, 0, 1, -16, 16);
      frame(0, 0, -1, 0, 1, -232, 16);
      frame(0, 0, -1, 0, 1, -8, 16);
      drain();

      // All-ones table, d=4096: three warm-up zeros then 64
      for (int f = 0; f < 6; f++) frame(1, 4096, -1, 0, 1, (f < 3) ? 0 : 64, (f == 0) ? 0 : 16);
      drain();

      // Same data with en every cycle and every third cycle
      do_clr(1, 1'b0, 0);
      for (int f = 0; f < 7; f++) frame(1, units1[f]*256, -1, 0, 1, exp1[f], (f == 0) ? 0 : 16);
      drain();
      do_clr(1, 1'b0, 0);
      for (int f = 0; f < 7; f++) frame(1, units1[f]*256, -1, 0, 3, exp1[f], (f == 0) ? 0 : 48);
      drain();
      repeat (40) idle();
      check("hold_q_dut1", int'(q[1]), 1);
      check("hold_valid_dut1", int'(q_valid[1]), 0);

      // clr at phase 7 with coincident en: q held, phase and warm-up restart
      run(1, 768, 7);
      do_clr(1, 1'b1, 30000);
      check("clr_q_held", int'(q[1]), 1);
      check("clr_no_valid", int'(q_valid[1]), 0);
      for (int f = 0; f < 4; f++) frame(1, 512, -1, 0, 1, (f < 3) ? 0 : 8, (f == 0) ? 0 : 16);
      drain();

      // rst_n at phase 7 with coincident en
      run(2, 32767, 7);
      rst_n  = 1'b0;
      en[2]  = 1'b1;
      d[2]   = 16'sd1000;
      @(posedge clk); #1;
      en[2]  = 1'b0;
      check("rst_mid_q_dut1", int'(q[1]), 0);
      check("rst_mid_valid_dut2", int'(q_valid[2]), 0);
      rst_n = 1'b1;
      idle();

      // Saturation with all-255 table, including floor of -8160>>>12 = -2
      for (int f = 0; f < 4; f++) frame(2, 32767, -1, 0, 1, (f < 3) ? 0 : 32767, (f == 0) ? 0 : 16);
      frame(2, -32768, -1, 0, 1, 32767, 16);
      frame(2, -32768, -1, 0, 1, -2, 16);
      frame(2, -32768, -1, 0, 1, -32768, 16);
      frame(2, -32768, -1, 0, 1, -32768, 16);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
